single_port_sync_ram_large: RTL and testbench

- Word-addressable single-port RAM: synchronous write, shared bidirectional tri-state data bus.
- Main memory of the accumulator CPU; holds program and data; PC/MAR drive `addr`.
- Read path is combinational by default, so data is valid in the same cycle the address and strobes are applied.
- A registered read path is selectable at compile time.

---
 rtl/mem_pkg.sv | 12 +
 rtl/single_port_sync_ram_large.sv | 71 +++++++
 tb/tb_single_port_sync_ram_large.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-system constants for the accumulator CPU.
//   DEFAULT_ADDR_WIDTH : default word-address width (32K words)
//   DEFAULT_DATA_WIDTH : default word width
//   RESET_VECTOR       : address the CPU fetches from after reset (program load base)
package mem_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 15;
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  localparam logic [15:0] RESET_VECTOR = 16'h0100;

endpackage : mem_pkg

// File: rtl/single_port_sync_ram_large.sv
// Single-port word-addressable RAM, main memory of the accumulator CPU.
// Synchronous write, shared bidirectional tri-state data bus.
//
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   rst_n    : synchronous active-low reset; blocks writes and releases the bus
//              (storage contents are kept)
//   addr     : word address
//   data     : shared bus; sampled on writes, driven by the RAM on reads, else high-Z
//   cs_input : chip select, active-high
//   we       : write enable, active-high; while set the RAM never drives the bus
//   oe       : output enable, active-high
//
// Build option:
//   SP_RAM_READ_REG_EN : when defined, reads come from a register sampled on the
//                        clock edge (1-cycle latency); otherwise reads are combinational.
module single_port_sync_ram_large
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // Contents start at zero; reset deliberately leaves them alone.
  logic [DATA_WIDTH-1:0] mem_q [Depth] = '{default: '0};

  logic                  wr_en;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] rd_word;

  // An X on we/cs_input makes the if-condition non-true, so no write occurs.
  assign wr_en    = rst_n && cs_input && we;
  // Write has priority: the bus belongs to the master whenever we is set.
  assign drive_en = rst_n && cs_input && oe && !we;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= data;
    end
  end

`ifdef SP_RAM_READ_REG_EN
  logic [DATA_WIDTH-1:0] rd_q;

  // Samples only when we=0, so a write edge never loads the register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (cs_input && !we) begin
      rd_q <= mem_q[addr];
    end
  end

  assign rd_word = rd_q;
`else
  assign rd_word = mem_q[addr];
`endif

  assign data = drive_en ? rd_word : {DATA_WIDTH{1'bz}};

endmodule : single_port_sync_ram_large

// File: tb/tb_single_port_sync_ram_large.sv
module tb_single_port_sync_ram_large;
  import mem_pkg::*;

  localparam int unsigned AW = DEFAULT_ADDR_WIDTH;
  localparam int unsigned DW = DEFAULT_DATA_WIDTH;
  // With the pull-up an undriven bus reads all ones.
  localparam logic [DW-1:0] BUS_Z = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          cs_input;
  logic          we;
  logic          oe;
  logic          drv;
  logic [DW-1:0] wdata;
  wire  [DW-1:0] data_bus;

  assign data_bus = drv ? wdata : {DW{1'bz}};
  pullup (data_bus);

  always #5 clk = ~clk;

  single_port_sync_ram_large #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .data    (data_bus),
    .cs_input(cs_input),
    .we      (we),
    .oe      (oe)
  );

  typedef struct {
    string         name;
    bit            rst_n;
    bit            cs;
    bit            we;
    bit            oe;
    bit            drv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input string name, input bit r, input bit c, input bit w,
                              input bit o, input bit d, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input bit chk,
                              input logic [DW-1:0] exp);
    vec_t v;
    v.name = name; v.rst_n = r; v.cs = c; v.we = w; v.oe = o; v.drv = d;
    v.addr = a; v.wdata = wd; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: data=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; cs_input = v.cs; we = v.we; oe = v.oe; drv = v.drv;
    addr = v.addr; wdata = v.wdata;
  endtask

  // One vector per cycle: inputs change just after the rising edge, any write
  // commits at the next rising edge, checks sample at the falling edge.
  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    drive(v);
`ifdef SP_RAM_READ_REG_EN
    if (v.chk && !v.we) begin
      @(posedge clk); #1;
    end
`endif
    @(negedge clk);
    if (v.chk) check(v.name, data_bus, v.exp);
  endtask

  // Write helper for the hand-written sequences.
  function automatic vec_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return mk("wr", 1, 1, 1, 0, 1, a, d, 0, '0);
  endfunction

  function automatic vec_t rd(input string n, input logic [AW-1:0] a, input logic [DW-1:0] e);
    return mk(n, 1, 1, 0, 1, 0, a, '0, 1, e);
  endfunction

  initial begin
    logic [AW-1:0] base;
    base = AW'(RESET_VECTOR);
    drive(mk("idle", 0, 0, 0, 0, 0, '0, '0, 0, '0));

    vecs.push_back(mk("reset_bus_z", 0, 1, 0, 1, 0, '0, '0, 1, BUS_Z));
    // Program load
    vecs.push_back(wr(base + 15'h00, 16'h110C));
    vecs.push_back(wr(base + 15'h01, 16'h210E));
    vecs.push_back(wr(base + 15'h0B, 16'h0005));
    vecs.push_back(wr(base + 15'h0F, 16'hFFFF));
    vecs.push_back(rd("load_100", base + 15'h00, 16'h110C));
    vecs.push_back(rd("load_101", base + 15'h01, 16'h210E));
    vecs.push_back(rd("load_10b", base + 15'h0B, 16'h0005));
    vecs.push_back(rd("load_10f", base + 15'h0F, 16'hFFFF));
    // Bus release
    vecs.push_back(mk("z_oe0", 1, 1, 0, 0, 0, base, '0, 1, BUS_Z));
    vecs.push_back(mk("z_cs0", 1, 0, 0, 1, 0, base, '0, 1, BUS_Z));
    vecs.push_back(mk("z_in_reset", 0, 1, 0, 1, 0, base, '0, 1, BUS_Z));
    vecs.push_back(mk("we_oe_bus", 1, 1, 1, 1, 1, 15'h0102, 16'h1234, 1, 16'h1234));
    vecs.push_back(rd("we_oe_written", 15'h0102, 16'h1234));
    // Chip deselect blocks write
    vecs.push_back(mk("cs0_write", 1, 0, 1, 0, 1, 15'h010D, 16'hAAAA, 0, '0));
    vecs.push_back(rd("cs0_no_write", 15'h010D, 16'h0000));
    // Reset blocks write, contents retained
    vecs.push_back(mk("rst_write", 0, 1, 1, 0, 1, 15'h010E, 16'h5555, 0, '0));
    vecs.push_back(rd("rst_no_write", 15'h010E, 16'h0000));
    vecs.push_back(rd("rst_retained", 15'h010B, 16'h0005));
    // Address boundaries
    vecs.push_back(wr(15'h7FFF, 16'hBEEF));
    vecs.push_back(wr(15'h0000, 16'h1357));
    vecs.push_back(rd("top_addr", 15'h7FFF, 16'hBEEF));
    vecs.push_back(rd("bottom_addr", 15'h0000, 16'h1357));
    vecs.push_back(rd("untouched_4000", 15'h4000, 16'h0000));
    // Store then load
    vecs.push_back(wr(15'h010E, 16'h0023));
    vecs.push_back(rd("store_load", 15'h010E, 16'h0023));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset asserted across several write edges, then released.
    apply(wr(15'h0300, 16'h1111));
    apply(mk("rst_hold1", 0, 1, 1, 0, 1, 15'h0300, 16'h2222, 0, '0));
    apply(mk("rst_hold2", 0, 1, 1, 1, 1, 15'h0300, 16'h3333, 0, '0));
    apply(rd("rst_multi_kept", 15'h0300, 16'h1111));

`ifdef SP_RAM_READ_REG_EN
    // Register mode: register holds the word sampled at the last edge.
    @(posedge clk); #1;
    drive(rd("", 15'h0100, '0));
    @(posedge clk); #1;
    addr = 15'h0101;
    #2 check("reg_holds_old", data_bus, 16'h110C);
    @(posedge clk); #1;
    check("reg_next_word", data_bus, 16'h210E);
`else
    // Combinational mode: address changes show up without a clock edge.
    @(posedge clk); #1;
    drive(rd("", 15'h0100, '0));
    #1 check("comb_same_cycle_a", data_bus, 16'h110C);
    addr = 15'h0101;
    #1 check("comb_same_cycle_b", data_bus, 16'h210E);
    oe = 1'b0;
    #1 check("comb_oe_release", data_bus, BUS_Z);
`endif

    @(posedge clk); #1;
    drive(mk("idle", 1, 0, 0, 0, 0, '0, '0, 0, '0));
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_single_port_sync_ram_large
